// File: rtl/clk_src_select_ctrl.sv
// Glitch-free clock source selection controller.
// Synchronises per-source health, qualifies each source with a holdoff counter, and drives a
// one-hot select for a BUFGCTRL-style mux chain with a dead gap between deselect and select.
// Optional feature: define CLK_SEL_STATS_EN to enable the saturating switch_count statistic;
// otherwise switch_count is tied to zero.
module clk_src_select_ctrl #(
  parameter int unsigned N_SRC          = 2,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned HOLDOFF_CYCLES = 1024,
  parameter int unsigned SWITCH_GAP     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_SRC-1:0]           src_ok,
  input  logic                       force_en,
  input  logic [$clog2(N_SRC)-1:0]   force_sel,
  output logic [N_SRC-1:0]           sel_onehot,
  output logic [$clog2(N_SRC)-1:0]   active_src,
  output logic                       no_src,
  output logic                       switching,
  output logic                       force_fault,
  output logic [15:0]                switch_count
);

  localparam int unsigned SEL_W = $clog2(N_SRC);
  localparam int unsigned PAD_W = 1 << SEL_W;
  localparam int unsigned CNT_W = $clog2(HOLDOFF_CYCLES + 1);
  localparam int unsigned GAP_W = $clog2(SWITCH_GAP + 1);
  localparam logic [CNT_W-1:0] HOLD     = CNT_W'(HOLDOFF_CYCLES);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(SWITCH_GAP - 1);

  typedef enum logic [1:0] {StNone, StGap, StActive} state_e;

  logic [N_SRC-1:0] sync_q [SYNC_STAGES];
  logic [N_SRC-1:0] ok_s;
  logic [CNT_W-1:0] cnt_q  [N_SRC];
  logic [N_SRC-1:0] stable;
  // Padded to the full index range so any force_sel / active_src value indexes safely;
  // entries beyond N_SRC read as zero, which also covers the force_sel < N_SRC check.
  logic [PAD_W-1:0] stable_pad;
  logic [PAD_W-1:0] ok_pad;
  logic             auto_valid;
  logic [SEL_W-1:0] auto_idx;
  logic             force_ok;
  logic             tgt_valid;
  logic [SEL_W-1:0] tgt_idx;
  logic             gap_done;

  state_e           state_q;
  logic [GAP_W-1:0] gap_q;

  assign ok_s = sync_q[SYNC_STAGES-1];

  // Multi-flop synchroniser for the asynchronous health inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= src_ok;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  // Per-source holdoff counters: any synced drop restarts qualification.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_SRC; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (!ok_s[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] != HOLD) begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Stability flags and target selection (forced source wins only when valid and stable).
  always_comb begin
    stable     = '0;
    stable_pad = '0;
    ok_pad     = '0;
    auto_valid = 1'b0;
    auto_idx   = '0;
    for (int i = 0; i < N_SRC; i++) stable[i] = (cnt_q[i] == HOLD);
    stable_pad[N_SRC-1:0] = stable;
    ok_pad[N_SRC-1:0]     = ok_s;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (stable[i]) begin
        auto_valid = 1'b1;
        auto_idx   = SEL_W'(i);
      end
    end
    force_ok  = force_en && stable_pad[force_sel];
    tgt_valid = force_ok || auto_valid;
    tgt_idx   = force_ok ? force_sel : auto_idx;
    gap_done  = (gap_q == GAP_LAST);
  end

  // Registered force fault flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      force_fault <= 1'b0;
    end else begin
      force_fault <= force_en && !force_ok;
    end
  end

  // Selection FSM; active_src doubles as the current-source register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StNone;
      gap_q      <= '0;
      sel_onehot <= '0;
      active_src <= '0;
      no_src     <= 1'b1;
      switching  <= 1'b0;
    end else begin
      case (state_q)
        StNone: begin
          if (tgt_valid) begin
            state_q   <= StGap;
            gap_q     <= '0;
            switching <= 1'b1;
          end
        end
        StActive: begin
          // Failover on loss of the current source takes priority but shares the same gap.
          if (!ok_pad[active_src] || (tgt_valid && (tgt_idx != active_src))) begin
            state_q    <= StGap;
            gap_q      <= '0;
            sel_onehot <= '0;
            no_src     <= 1'b1;
            switching  <= 1'b1;
          end
        end
        StGap: begin
          if (gap_done) begin
            switching <= 1'b0;
            if (tgt_valid) begin
              state_q    <= StActive;
              sel_onehot <= N_SRC'(1) << tgt_idx;
              active_src <= tgt_idx;
              no_src     <= 1'b0;
            end else begin
              state_q <= StNone;
            end
          end else begin
            gap_q <= gap_q + GAP_W'(1);
          end
        end
        default: begin
          state_q    <= StNone;
          sel_onehot <= '0;
          no_src     <= 1'b1;
          switching  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CLK_SEL_STATS_EN
  logic [15:0] switch_count_q;

  // Count completed GAP->ACTIVE transitions, saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      switch_count_q <= 16'h0000;
    end else if ((state_q == StGap) && gap_done && tgt_valid && (switch_count_q != 16'hFFFF)) begin
      switch_count_q <= switch_count_q + 16'd1;
    end
  end

  assign switch_count = switch_count_q;
`else
  assign switch_count = 16'h0000;
`endif

endmodule

// File: tb/tb_clk_src_select_ctrl.sv
// Directed bench for clk_src_select_ctrl (N_SRC=2, SYNC_STAGES=2, HOLDOFF=16, GAP=4).
module tb_clk_src_select_ctrl;

`ifdef CLK_SEL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [1:0]  src_ok;
  logic        force_en;
  logic [0:0]  force_sel;
  logic [1:0]  sel_onehot;
  logic [0:0]  active_src;
  logic        no_src;
  logic        switching;
  logic        force_fault;
  logic [15:0] switch_count;

  int total;
  int passed;

  clk_src_select_ctrl #(
    .N_SRC          (2),
    .SYNC_STAGES    (2),
    .HOLDOFF_CYCLES (16),
    .SWITCH_GAP     (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .src_ok       (src_ok),
    .force_en     (force_en),
    .force_sel    (force_sel),
    .sel_onehot   (sel_onehot),
    .active_src   (active_src),
    .no_src       (no_src),
    .switching    (switching),
    .force_fault  (force_fault),
    .switch_count (switch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  ok;
    logic        fen;
    logic [0:0]  fsel;
    int          cyc;
    logic [1:0]  sel;
    logic [0:0]  act;
    logic        nsrc;
    logic        sw;
    logic        ff;
    logic [15:0] cnt;
  } vec_t;

  vec_t rows [23];

  // Observed outputs packed; active_src only meaningful while a source is selected.
  function automatic logic [21:0] pack_dut();
    logic [0:0]  a;
    logic [15:0] c;
    a = no_src ? 1'b0 : active_src;
    c = switch_count;
    return {sel_onehot, no_src, switching, force_fault, a, c};
  endfunction

  function automatic logic [21:0] pack_exp(input logic [1:0] s, input logic [0:0] a,
                                           input logic n, input logic w, input logic f,
                                           input logic [15:0] c);
    logic [0:0]  am;
    logic [15:0] cm;
    am = n ? 1'b0 : a;
    cm = STATS ? c : 16'h0000;
    return {s, n, w, f, am, cm};
  endfunction

  task automatic check(input string name, input logic [21:0] got, input logic [21:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got {sel,no,sw,ff,act,cnt}=%h required %h", name, got, exp);
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Two select bits must never be high together.
  always @(negedge clk) begin
    if (!$onehot0(sel_onehot)) begin
      total++;
      $display("FAIL onehot: sel_onehot=%b required at most one bit", sel_onehot);
    end
  end

  initial begin
    total     = 0;
    passed    = 0;
    rst       = 1'b1;
    src_ok    = 2'b00;
    force_en  = 1'b0;
    force_sel = 1'b0;

    //          ok    fen   fsel  cyc sel   act   no    sw    ff    cnt
    // Startup
    rows[0]  = '{2'b11, 1'b0, 1'b0, 18, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
    rows[1]  = '{2'b11, 1'b0, 1'b0, 1,  2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0};
    rows[2]  = '{2'b11, 1'b0, 1'b0, 3,  2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0};
    rows[3]  = '{2'b11, 1'b0, 1'b0, 1,  2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
    // Failover of src 0
    rows[4]  = '{2'b10, 1'b0, 1'b0, 2,  2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
    rows[5]  = '{2'b10, 1'b0, 1'b0, 1,  2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 16'd1};
    rows[6]  = '{2'b10, 1'b0, 1'b0, 3,  2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 16'd1};
    rows[7]  = '{2'b10, 1'b0, 1'b0, 1,  2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2};
    // Hysteresis: 10-cycle pulse ignored, long assertion preempts
    rows[8]  = '{2'b11, 1'b0, 1'b0, 10, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2};
    rows[9]  = '{2'b10, 1'b0, 1'b0, 10, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2};
    rows[10] = '{2'b11, 1'b0, 1'b0, 18, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2};
    rows[11] = '{2'b11, 1'b0, 1'b0, 1,  2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 16'd2};
    rows[12] = '{2'b11, 1'b0, 1'b0, 4,  2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 16'd3};
    // Force to src 1, then release and preempt back
    rows[13] = '{2'b11, 1'b1, 1'b1, 1,  2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 16'd3};
    rows[14] = '{2'b11, 1'b1, 1'b1, 4,  2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 16'd4};
    rows[15] = '{2'b11, 1'b0, 1'b0, 1,  2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 16'd4};
    rows[16] = '{2'b11, 1'b0, 1'b0, 4,  2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 16'd5};
    // Force to a dead source
    rows[17] = '{2'b01, 1'b0, 1'b0, 4,  2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 16'd5};
    rows[18] = '{2'b01, 1'b1, 1'b1, 1,  2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 16'd5};
    rows[19] = '{2'b01, 1'b1, 1'b1, 5,  2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 16'd5};
    rows[20] = '{2'b01, 1'b0, 1'b0, 1,  2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 16'd5};
    // All sources fail
    rows[21] = '{2'b00, 1'b0, 1'b0, 3,  2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 16'd5};
    rows[22] = '{2'b00, 1'b0, 1'b0, 4,  2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 16'd5};

    run(3);
    check("reset", pack_dut(), pack_exp(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0));
    total++;
    if (active_src === 1'b0) passed++;
    else $display("FAIL reset_active_src: got %b required 0", active_src);

    src_ok = 2'b11;
    rst    = 1'b0;
    for (int i = 0; i < 23; i++) begin
      src_ok    = rows[i].ok;
      force_en  = rows[i].fen;
      force_sel = rows[i].fsel;
      run(rows[i].cyc);
      check($sformatf("row%0d", i), pack_dut(),
            pack_exp(rows[i].sel, rows[i].act, rows[i].nsrc, rows[i].sw, rows[i].ff,
                     rows[i].cnt));
    end

    // Reset in the middle of a gap, then a full holdoff after release.
    src_ok = 2'b11;
    run(20);
    check("gap_cycle2", pack_dut(), pack_exp(2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 16'd5));
    #2 rst = 1'b1;
    #1;
    check("async_reset", pack_dut(), pack_exp(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0));
    @(negedge clk);
    rst = 1'b0;
    run(18);
    check("post_reset_holdoff", pack_dut(), pack_exp(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0));
    run(1);
    check("post_reset_gap", pack_dut(), pack_exp(2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0));
    run(4);
    check("post_reset_select", pack_dut(), pack_exp(2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
